// File: rtl/sram_bridge.sv
// 32-bit CPU load/store to 16-bit async SRAM sequencer.
// Splits each word into low/high halfword phases with a programmable strobe.
module sram_bridge #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        busy,
  output logic [19:0] sram_addr,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_i,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [18:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic [19:0] sa_q, sa_d;
  logic [15:0] dqo_q, dqo_d;
  logic        dqoe_q, dqoe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        ub_n_q, ub_n_d;
  logic        lb_n_q, lb_n_d;
  logic        in_ph;
  logic        hi;
  logic [31:0] bmask;

  // Address bits outside the word index are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{cpu_addr[31:21], cpu_addr[1:0]};

  // Next state, request latch, read capture and next pin levels.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr[20:2];
          wdata_d = cpu_wdata;
          be_d    = cpu_be;
          cnt_d   = '0;
          if (cpu_be[1:0] != 2'b00)
            state_d = LO;
          else if (cpu_be[3:2] != 2'b00)
            state_d = HI;
          else
            state_d = DONE;
        end
      end
      LO, HI: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (!we_q) begin
            if (state_q == LO)
              rbuf_d[15:0] = sram_dq_i;
            else
              rbuf_d[31:16] = sram_dq_i;
          end
          if (state_q == LO && be_q[3:2] != 2'b00)
            state_d = HI;
          else
            state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    bmask = {{8{be_d[3]}}, {8{be_d[2]}},
             {8{be_d[1]}}, {8{be_d[0]}}};
    if (state_d == DONE && state_q != DONE && !we_d)
      rdata_d = rbuf_d & bmask;

    in_ph  = (state_d == LO) || (state_d == HI);
    hi     = (state_d == HI);
    ack_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
    ce_n_d = !in_ph;
    oe_n_d = !(in_ph && !we_d);
    dqoe_d = in_ph && we_d;
    we_n_d = !(in_ph && we_d && cnt_d != '0);
    ub_n_d = !(in_ph && (hi ? be_d[3] : be_d[1]));
    lb_n_d = !(in_ph && (hi ? be_d[2] : be_d[0]));
    sa_d   = in_ph ? {addr_d, hi} : 20'h0;
    dqo_d  = (in_ph && we_d) ?
             (hi ? wdata_d[31:16] : wdata_d[15:0]) : 16'h0;
  end

  // FSM state and registered pin outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      sa_q    <= '0;
      dqo_q   <= '0;
      dqoe_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      sa_q    <= sa_d;
      dqo_q   <= dqo_d;
      dqoe_q  <= dqoe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_ack    = ack_q;
  assign busy       = busy_q;
  assign sram_addr  = sa_q;
  assign sram_dq_o  = dqo_q;
  assign sram_dq_oe = dqoe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_ub_n  = ub_n_q;
  assign sram_lb_n  = lb_n_q;

endmodule
